// File: rtl/output_ctrl.sv
// Output-side controller of one NoC router link: round-robin arbitration over the
// requesters that route here, a small FIFO, and a valid/ready link interface.
module output_ctrl #(
  parameter int WIDTH_packet = 57,
  parameter int NUM_IN       = 5,
  parameter int DEPTH        = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_IN-1:0]              in_valid,
  input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
  output logic [NUM_IN-1:0]              in_ready,
  output logic                           out_valid,
  output logic [WIDTH_packet-1:0]        out_data,
  input  logic                           out_ready
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic [IDX_W-1:0]        last_grant;

  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        cand;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [WIDTH_packet-1:0] push_data;

  // Round-robin search starting just after the previous winner, wrapping.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_IN);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A pop in the same cycle does not make room: only count decides acceptance.
  assign accept    = !reset && (count < FULL_CNT);
  assign push      = accept && grant_found;
  assign in_ready  = push ? (NUM_IN'(1) << grant_idx) : '0;
  assign push_data = in_data[grant_idx*WIDTH_packet +: WIDTH_packet];

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= LAST_IDX;
    end else begin
      if (push) begin
        wr_ptr     <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        last_grant <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable because out_data is masked while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_output_ctrl.sv
// Directed checks of output_ctrl: reset, latency, round-robin order, back-pressure,
// simultaneous push/pop, plus a scoreboarded random phase.
module tb_output_ctrl;

  localparam int W      = 57;
  localparam int NUM_IN = 5;
  localparam int DEPTH  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*W-1:0]     in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [W-1:0]            out_data;
  logic                    out_ready;

  int checks   = 0;
  int failures = 0;

  output_ctrl #(.WIDTH_packet(W), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  function automatic logic [W-1:0] mk(input int src, input int seq);
    return {5'(src), 20'(seq), 32'hC0DE_0000 ^ 32'(seq * 13 + src * 7 + 1)};
  endfunction

  logic [W-1:0] cur  [NUM_IN];
  int           seqs [NUM_IN];
  logic [W-1:0] prev;
  logic [W-1:0] n1, e1, n2, s1;

  // random-phase model state
  logic [W-1:0] q [$];
  logic [W-1:0] pend_data [NUM_IN];
  bit           pend [NUM_IN];
  int           model_last;
  logic [NUM_IN-1:0] exp_ready;
  int           gidx;
  int           c;

  initial begin
    // ---- reset with all requesters asserting ----
    reset     = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      seqs[i] = 0;
      cur[i]  = mk(i, 0);
      set_data(i, cur[i]);
    end
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    step();
    step();
    check("rst_hold_out_valid", 64'(out_valid), 64'(0));

    // ---- single PE packet: latency ----
    reset     = 1'b0;
    in_valid  = 5'b10000;
    set_data(4, 57'h1_0000_DEAD_BEEF);
    out_ready = 1'b1;
    #1;
    check("pe_in_ready", 64'(in_ready), 64'(5'b10000));
    check("pe_out_valid_c0", 64'(out_valid), 64'(0));
    step();
    in_valid = '0;
    #1;
    check("pe_out_valid_c1", 64'(out_valid), 64'(1));
    check("pe_out_data_c1", 64'(out_data), 64'(57'h1_0000_DEAD_BEEF));
    check("pe_in_ready_c1", 64'(in_ready), 64'(0));
    step();
    check("pe_popped", 64'(out_valid), 64'(0));
    check("pe_empty_data", 64'(out_data), 64'(0));

    // ---- all five valid: grants rotate 0..4, one per cycle ----
    for (int i = 0; i < NUM_IN; i++) begin
      seqs[i] = 1;
      cur[i]  = mk(i, 1);
      set_data(i, cur[i]);
    end
    in_valid = '1;
    prev     = '0;
    for (int cy = 0; cy < 10; cy++) begin
      #1;
      check($sformatf("rr_grant_%0d", cy), 64'(in_ready), 64'(5'b00001 << (cy % NUM_IN)));
      if (cy > 0) begin
        check($sformatf("rr_valid_%0d", cy), 64'(out_valid), 64'(1));
        check($sformatf("rr_data_%0d", cy), 64'(out_data), 64'(prev));
      end
      prev = cur[cy % NUM_IN];
      step();
      seqs[cy % NUM_IN]++;
      cur[cy % NUM_IN] = mk(cy % NUM_IN, seqs[cy % NUM_IN]);
      set_data(cy % NUM_IN, cur[cy % NUM_IN]);
    end
    in_valid = '0;
    #1;
    check("rr_tail_data", 64'(out_data), 64'(prev));
    step();
    check("rr_drained", 64'(out_valid), 64'(0));

    // ---- back-pressure: north then east fill the FIFO ----
    n1 = mk(0, 100);
    e1 = mk(2, 100);
    n2 = mk(0, 101);
    out_ready = 1'b0;
    set_data(0, n1);
    set_data(2, e1);
    in_valid = 5'b00101;
    #1;
    check("bp_grant_north", 64'(in_ready), 64'(5'b00001));
    step();
    in_valid = 5'b00100;
    #1;
    check("bp_grant_east", 64'(in_ready), 64'(5'b00100));
    check("bp_head_north", 64'(out_data), 64'(n1));
    step();
    set_data(0, n2);
    in_valid  = 5'b00001;
    out_ready = 1'b1;
    #1;
    check("bp_full_no_grant", 64'(in_ready), 64'(0));
    check("bp_full_head", 64'(out_data), 64'(n1));
    step();
    // count=1 here: push of n2 and pop of e1 happen on the same edge
    #1;
    check("pp_head_east", 64'(out_data), 64'(e1));
    check("pp_grant_north", 64'(in_ready), 64'(5'b00001));
    step();
    in_valid = '0;
    #1;
    check("pp_head_n2", 64'(out_data), 64'(n2));
    check("pp_valid_n2", 64'(out_valid), 64'(1));
    step();
    check("pp_drained", 64'(out_valid), 64'(0));

    // ---- reset mid-traffic with two packets queued ----
    out_ready = 1'b0;
    set_data(3, mk(3, 200));
    set_data(4, mk(4, 200));
    in_valid = 5'b11000;
    #1;
    check("mr_grant_west", 64'(in_ready), 64'(5'b01000));
    step();
    in_valid = 5'b10000;
    #1;
    check("mr_grant_pe", 64'(in_ready), 64'(5'b10000));
    step();
    in_valid = 5'b00001;
    #1;
    check("mr_full_no_grant", 64'(in_ready), 64'(0));
    check("mr_full_valid", 64'(out_valid), 64'(1));
    #1;
    reset = 1'b1;
    #1;
    check("mr_rst_out_valid", 64'(out_valid), 64'(0));
    check("mr_rst_out_data", 64'(out_data), 64'(0));
    check("mr_rst_in_ready", 64'(in_ready), 64'(0));
    step();
    s1 = mk(1, 300);
    set_data(1, s1);
    set_data(3, mk(3, 300));
    in_valid = 5'b01010;
    reset    = 1'b0;
    #1;
    check("mr_first_grant", 64'(in_ready), 64'(5'b00010));
    check("mr_post_valid", 64'(out_valid), 64'(0));
    step();
    in_valid = '0;
    #1;
    check("mr_post_data", 64'(out_data), 64'(s1));
    out_ready = 1'b1;
    step();
    check("mr_drained", 64'(out_valid), 64'(0));

    // ---- random traffic against a queue scoreboard ----
    reset    = 1'b1;
    in_valid = '0;
    step();
    reset      = 1'b0;
    model_last = NUM_IN - 1;
    for (int i = 0; i < NUM_IN; i++) begin
      pend[i]  = 1'b0;
      seqs[i]  = 1000;
    end
    for (int cy = 0; cy < 1500; cy++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]      = 1'b1;
          seqs[i]++;
          pend_data[i] = mk(i, seqs[i]);
        end
        in_valid[i] = pend[i];
        set_data(i, pend[i] ? pend_data[i] : mk(i, 0));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = '0;
      gidx      = -1;
      if (q.size() < DEPTH) begin
        for (int k = 1; k <= NUM_IN; k++) begin
          c = (model_last + k) % NUM_IN;
          if (gidx < 0 && in_valid[c]) gidx = c;
        end
        if (gidx >= 0) exp_ready[gidx] = 1'b1;
      end
      check("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
      check("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_out_data", 64'(out_data), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
      if (gidx >= 0) begin
        q.push_back(pend_data[gidx]);
        model_last = gidx;
        pend[gidx] = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
